// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory controller: RAM arbiter states and the
// request record latched when a port is granted.
package rv32ima_pkg;

  localparam int XLEN  = 32;
  localparam int XSTRB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [XSTRB-1:0] strb;
    logic             wen;
  } arb_req_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between instruction fetch (I) and load/store (D):
// one access in flight, D-over-I priority with a starvation override, and a response timeout.
module ram_port_arbiter
  import rv32ima_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                ram_ren,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_store,
  output logic [DATA_W/8-1:0] ram_strb,
  input  logic [DATA_W-1:0]   ram_load,
  input  logic                ram_ready,
  output logic                bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    state_q;
  arb_req_t      req_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;

  logic i_pend;
  logic d_pend;
  logic d_wins;
  logic timed_out;
  logic granted;

  // A port whose ack is showing is still holding its old request, so it is ignored.
  assign i_pend    = i_req & ~i_ack;
  assign d_pend    = (d_ren | d_wen) & ~d_ack;
  assign d_wins    = d_pend & (~i_pend | (starve_q < SW'(STARVE_MAX)));
  assign timed_out = (TIMEOUT > 0) && !ram_ready && (tmo_q == TW'(TIMEOUT - 1));

  assign granted   = (state_q != IDLE);
  assign ram_ren   = (state_q == GRANT_I) || ((state_q == GRANT_D) && !req_q.wen);
  assign ram_wen   = (state_q == GRANT_D) && req_q.wen;
  assign ram_addr  = granted ? req_q.addr[ADDR_W-1:0]    : '0;
  assign ram_store = granted ? req_q.wdata[DATA_W-1:0]   : '0;
  assign ram_strb  = granted ? req_q.strb[DATA_W/8-1:0]  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      bus_err  <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (d_wins) begin
            state_q     <= GRANT_D;
            req_q.addr  <= XLEN'(d_addr);
            req_q.wdata <= XLEN'(d_wdata);
            req_q.strb  <= d_wen ? XSTRB'(d_strb) : '1;
            req_q.wen   <= d_wen;
            if (i_pend)
              starve_q <= starve_q + 1'b1;
            else if (!i_req)
              starve_q <= '0;
          end else if (i_pend) begin
            state_q     <= GRANT_I;
            req_q.addr  <= XLEN'(i_addr);
            req_q.wdata <= '0;
            req_q.strb  <= '1;
            req_q.wen   <= 1'b0;
            starve_q    <= '0;
          end else if (!i_req) begin
            starve_q <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          // A RAM response arriving on the last allowed cycle still counts as success.
          if (ram_ready || timed_out) begin
            state_q <= IDLE;
            bus_err <= ~ram_ready;
            if (state_q == GRANT_I) begin
              i_ack   <= 1'b1;
              i_rdata <= ram_ready ? ram_load : '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= (ram_ready && !req_q.wen) ? ram_load : '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a cycle-level reference model.
module tb_ram_port_arbiter;

  localparam int STARVE = 2;
  localparam int TMO    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [3:0]  ram_strb;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        bus_err;

  int checks = 0;
  int passes = 0;

  ram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_strb(d_strb), .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_strb(ram_strb), .ram_load(ram_load),
    .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strb;
    logic        ram_ready;
    logic [31:0] ram_load;
    logic        e_i_ack;
    logic        e_d_ack;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_store;
    logic [31:0] e_i_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[9];

  // Reference model state: what the outputs should show in the current cycle.
  int          m_owner;
  int          m_wait;
  int          m_starve;
  int          m_delay;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic [3:0]  m_strb;
  logic        m_wen;
  logic        m_i_ack;
  logic        m_d_ack;
  logic        m_err;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  bit          i_act;
  bit          d_act;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_i_ack"}, i_ack, 0);
    check_output({tag, "_d_ack"}, d_ack, 0);
    check_output({tag, "_bus_err"}, bus_err, 0);
    check_output({tag, "_ram_ren"}, ram_ren, 0);
    check_output({tag, "_ram_wen"}, ram_wen, 0);
    check_output({tag, "_ram_addr"}, ram_addr, 0);
    check_output({tag, "_ram_store"}, ram_store, 0);
    check_output({tag, "_ram_strb"}, ram_strb, 0);
    check_output({tag, "_i_rdata"}, i_rdata, 0);
    check_output({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    i_req     = v.i_req;
    i_addr    = v.i_addr;
    d_ren     = v.d_ren;
    d_wen     = v.d_wen;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    d_strb    = v.d_strb;
    ram_ready = v.ram_ready;
    ram_load  = v.ram_load;
  endtask

  task automatic check_vector(input int r, input vec_t v);
    check_output($sformatf("row%0d_i_ack", r), i_ack, v.e_i_ack);
    check_output($sformatf("row%0d_d_ack", r), d_ack, v.e_d_ack);
    check_output($sformatf("row%0d_bus_err", r), bus_err, 0);
    check_output($sformatf("row%0d_ram_ren", r), ram_ren, v.e_ren);
    check_output($sformatf("row%0d_ram_wen", r), ram_wen, v.e_wen);
    check_output($sformatf("row%0d_ram_addr", r), ram_addr, v.e_addr);
    check_output($sformatf("row%0d_ram_strb", r), ram_strb, v.e_strb);
    check_output($sformatf("row%0d_i_rdata", r), i_rdata, v.e_i_rdata);
    check_output($sformatf("row%0d_d_rdata", r), d_rdata, v.e_d_rdata);
    if (v.e_wen)
      check_output($sformatf("row%0d_ram_store", r), ram_store, v.e_store);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_advance();
    bit i_live;
    bit d_live;
    i_live  = i_req && !m_i_ack;
    d_live  = (d_ren || d_wen) && !m_d_ack;
    m_i_ack = 1'b0;
    m_d_ack = 1'b0;
    m_err   = 1'b0;
    if (m_owner == 0) begin
      if (d_live && (!i_live || m_starve < STARVE)) begin
        m_owner = 2;
        m_addr  = d_addr;
        m_wen   = d_wen;
        m_strb  = d_wen ? d_strb : 4'hF;
        m_store = d_wdata;
        if (i_live) m_starve = m_starve + 1;
        else if (!i_req) m_starve = 0;
      end else if (i_live) begin
        m_owner  = 1;
        m_addr   = i_addr;
        m_wen    = 1'b0;
        m_strb   = 4'hF;
        m_store  = '0;
        m_starve = 0;
      end else if (!i_req) begin
        m_starve = 0;
      end
      m_wait  = 0;
      m_delay = $urandom_range(0, 5);
    end else if (ram_ready || m_wait == TMO - 1) begin
      m_err = !ram_ready;
      if (m_owner == 1) begin
        m_i_ack   = 1'b1;
        m_i_rdata = ram_ready ? ram_load : 32'h0;
      end else begin
        m_d_ack   = 1'b1;
        m_d_rdata = (ram_ready && !m_wen) ? ram_load : 32'h0;
      end
      m_owner = 0;
    end else begin
      m_wait = m_wait + 1;
    end
  endtask

  task automatic model_compare();
    check_output("rnd_ram_ren", ram_ren, (m_owner == 1) || (m_owner == 2 && !m_wen));
    check_output("rnd_ram_wen", ram_wen, (m_owner == 2) && m_wen);
    check_output("rnd_ram_addr", ram_addr, (m_owner != 0) ? m_addr : 32'h0);
    check_output("rnd_ram_strb", ram_strb, (m_owner != 0) ? m_strb : 4'h0);
    if (m_owner == 2 && m_wen)
      check_output("rnd_ram_store", ram_store, m_store);
    check_output("rnd_i_ack", i_ack, m_i_ack);
    check_output("rnd_d_ack", d_ack, m_d_ack);
    check_output("rnd_bus_err", bus_err, m_err);
    check_output("rnd_i_rdata", i_rdata, m_i_rdata);
    check_output("rnd_d_rdata", d_rdata, m_d_rdata);
    check_output("rnd_one_ack", i_ack & d_ack, 0);
    check_output("rnd_one_enable", ram_ren & ram_wen, 0);
  endtask

  // Requesters hold a request until acked and keep the stale request up during the ack cycle.
  task automatic drive_random(input bit gen);
    int op;
    if (m_i_ack) begin
      i_act = 1'b0;
    end else if (!i_act) begin
      if (gen && $urandom_range(0, 2) != 0) begin
        i_act  = 1'b1;
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end else begin
        i_req = 1'b0;
      end
    end
    if (m_d_ack) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (gen && $urandom_range(0, 2) != 0) begin
        op      = $urandom_range(0, 2);
        d_act   = 1'b1;
        d_ren   = (op != 1);
        d_wen   = (op != 0);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_strb  = 4'($urandom_range(1, 15));
      end else begin
        d_ren = 1'b0;
        d_wen = 1'b0;
      end
    end
    if (m_owner != 0)
      ram_ready = (m_wait == m_delay);
    else
      ram_ready = ($urandom_range(0, 3) == 0);
    ram_load = $urandom;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] grants[$];
    int d_ack_t;
    int i_ack_t;
    bit quiet;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 4'h3, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b1, 32'hFFFFFFFF,
                1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0};

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; d_strb = '0; ram_ready = 1'b0; ram_load = '0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 9; r++) begin
      apply_stimulus(vecs[r]);
      tick();
      check_vector(r, vecs[r]);
    end
    apply_stimulus('{default: '0});
    tick();

    // Both ports held: D wins first, and its own ack masks it so I takes the next slot.
    i_req = 1'b1; i_addr = 32'h400; d_ren = 1'b1; d_addr = 32'h200;
    ram_load = 32'h0BADC0DE;
    d_ack_t = -1;
    i_ack_t = -1;
    for (int cyc = 0; cyc < 40 && grants.size() < 6; cyc++) begin
      tick();
      check_output("cont_one_ack", i_ack & d_ack, 0);
      check_output("cont_one_enable", ram_ren & ram_wen, 0);
      if (d_ack && d_ack_t < 0) d_ack_t = cyc;
      if (i_ack && i_ack_t < 0) i_ack_t = cyc;
      ram_ready = ram_ren | ram_wen;
      if (ram_ren | ram_wen) grants.push_back(ram_addr);
    end
    i_req = 1'b0; d_ren = 1'b0;
    check_output("cont_grant_count", 32'(grants.size()), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++)
      check_output($sformatf("cont_grant_%0d", k), grants[k], (k % 2 == 0) ? 32'h200 : 32'h400);
    check_output("cont_i_ack_after_d_ack", 32'(i_ack_t - d_ack_t), 2);
    tick();
    ram_ready = 1'b0;
    tick();
    tick();

    // RAM never answers: four GRANT cycles, then an error ack with zero data.
    i_req = 1'b1; i_addr = 32'h500;
    for (int k = 1; k <= TMO; k++) begin
      tick();
      check_output($sformatf("tmo_ren_c%0d", k), ram_ren, 1);
      check_output($sformatf("tmo_no_ack_c%0d", k), i_ack, 0);
    end
    tick();
    check_output("tmo_i_ack", i_ack, 1);
    check_output("tmo_bus_err", bus_err, 1);
    check_output("tmo_i_rdata", i_rdata, 0);
    check_output("tmo_ren_off", ram_ren, 0);
    tick();
    check_output("tmo_no_regrant", ram_ren, 0);
    check_output("tmo_err_pulse", bus_err, 0);
    i_req = 1'b0;
    tick();

    // Ready on the final allowed cycle is a success.
    d_ren = 1'b1; d_addr = 32'h600; ram_load = 32'h55AA55AA;
    for (int k = 0; k < TMO; k++) tick();
    ram_ready = 1'b1;
    tick();
    check_output("late_d_ack", d_ack, 1);
    check_output("late_bus_err", bus_err, 0);
    check_output("late_d_rdata", d_rdata, 32'h55AA55AA);
    ram_ready = 1'b0; d_ren = 1'b0;
    tick();

    // Withdrawal mid-grant still completes with an ack.
    d_ren = 1'b1; d_addr = 32'h700; ram_load = 32'h13572468;
    tick();
    d_ren = 1'b0;
    tick();
    ram_ready = 1'b1;
    tick();
    check_output("wd_d_ack", d_ack, 1);
    check_output("wd_d_rdata", d_rdata, 32'h13572468);
    ram_ready = 1'b0;
    tick();

    // Reset during GRANT_D abandons the access.
    d_ren = 1'b1; d_addr = 32'h800;
    tick();
    check_output("rstmid_ren", ram_ren, 1);
    check_output("rstmid_addr", ram_addr, 32'h800);
    rst = 1'b1;
    tick();
    check_idle_zero("rstmid");
    rst = 1'b0; d_ren = 1'b0;
    tick();
    check_output("rstmid_no_d_ack", d_ack, 0);
    check_output("rstmid_no_ren", ram_ren, 0);
    i_req = 1'b1; i_addr = 32'h900;
    tick();
    check_output("post_rst_ren", ram_ren, 1);
    check_output("post_rst_addr", ram_addr, 32'h900);
    ram_ready = 1'b1; ram_load = 32'h2468ACE0;
    tick();
    check_output("post_rst_i_ack", i_ack, 1);
    check_output("post_rst_i_rdata", i_rdata, 32'h2468ACE0);
    ram_ready = 1'b0;
    tick();
    i_req = 1'b0;

    // Random traffic against the reference model, starting from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_owner = 0; m_wait = 0; m_starve = 0; m_delay = 0;
    m_addr = '0; m_store = '0; m_strb = '0; m_wen = 1'b0;
    m_i_ack = 1'b0; m_d_ack = 1'b0; m_err = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0;
    i_act = 1'b0; d_act = 1'b0;
    quiet = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      drive_random(cyc < 400);
      model_advance();
      tick();
      model_compare();
      quiet = (m_owner == 0) && !i_act && !d_act && !m_i_ack && !m_d_ack;
      if (cyc >= 400 && quiet) break;
    end
    check_output("rnd_drain", quiet, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
